// File: rtl/ddr2_pattern_gen_chk.sv
// DDR2 tester traffic source/sink: writes a deterministic LFSR or index pattern into the ib_ FIFO and checks ob_ FIFO data.
// Define DDR2_PATTERN_ERR_CAPTURE_EN to add first-mismatch capture outputs.
module ddr2_pattern_gen_chk #(
  parameter int          FIFO_SIZE  = 1024,
  parameter int          WORD_CNT_W = 25,
  parameter logic [31:0] LFSR_POLY  = 32'h80200003
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pattern_sel,
  input  logic [31:0]           seed,
  input  logic [WORD_CNT_W-1:0] word_count,
  output logic                  ib_we,
  output logic [31:0]           ib_din,
  input  logic [10:0]           ib_count,
  output logic                  ob_re,
  input  logic [31:0]           ob_dout,
  input  logic                  ob_empty,
  output logic                  gen_done,
  output logic                  chk_done,
  output logic [31:0]           err_count,
  output logic [WORD_CNT_W-1:0] words_checked
`ifdef DDR2_PATTERN_ERR_CAPTURE_EN
  ,
  output logic                  first_err_valid,
  output logic [WORD_CNT_W-1:0] first_err_idx,
  output logic [31:0]           first_err_exp,
  output logic [31:0]           first_err_got
`endif
);

  typedef enum logic [1:0] {GEN_IDLE, GEN_RUN, GEN_DONE} gen_state_e;
  typedef enum logic [1:0] {CHK_IDLE, CHK_RUN, CHK_DONE} chk_state_e;

  // Two words of slack cover the FIFO fill-level reporting latency.
  localparam logic [10:0] FULL_THRESH = 11'(FIFO_SIZE - 2);

  gen_state_e            gen_state_q, gen_state_d;
  chk_state_e            chk_state_q, chk_state_d;
  logic [31:0]           gen_word_q;
  logic [31:0]           exp_word_q;
  logic [WORD_CNT_W-1:0] written_q;
  logic [WORD_CNT_W-1:0] rd_issued_q;
  logic [WORD_CNT_W-1:0] wc_q;
  logic [WORD_CNT_W-1:0] words_checked_q;
  logic [31:0]           err_count_q;
  logic                  sel_q;
  logic                  rd_vld_q;
  logic                  we;
  logic                  re;
  logic                  cmp_en;
  logic                  mismatch;
  logic [31:0]           seed_eff;

  function automatic logic [31:0] lfsr_next(input logic [31:0] w);
    return (w >> 1) ^ (w[0] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [31:0] pat_next(input logic [31:0] w, input logic idx_mode);
    return idx_mode ? (w + 32'd1) : lfsr_next(w);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  assign seed_eff = pattern_sel ? 32'h0 : ((seed == 32'h0) ? 32'h1 : seed);
  assign cmp_en   = rd_vld_q && !start && (chk_state_q == CHK_RUN);
  assign mismatch = (ob_dout != exp_word_q);

  // Generator FSM
  always_comb begin
    gen_state_d = gen_state_q;
    we          = 1'b0;
    if (start) begin
      gen_state_d = (word_count == '0) ? GEN_DONE : GEN_RUN;
    end else begin
      case (gen_state_q)
        GEN_RUN: begin
          we = (ib_count < FULL_THRESH) && (written_q != wc_q);
          if (we && ((written_q + 1'b1) == wc_q)) gen_state_d = GEN_DONE;
        end
        default: ;
      endcase
    end
  end

  // Checker FSM
  always_comb begin
    chk_state_d = chk_state_q;
    re          = 1'b0;
    if (start) begin
      chk_state_d = (word_count == '0) ? CHK_DONE : CHK_RUN;
    end else begin
      case (chk_state_q)
        CHK_RUN: begin
          re = !ob_empty && (rd_issued_q != wc_q);
          if (cmp_en && ((words_checked_q + 1'b1) == wc_q)) chk_state_d = CHK_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gen_state_q     <= GEN_IDLE;
      chk_state_q     <= CHK_IDLE;
      rd_vld_q        <= 1'b0;
      words_checked_q <= '0;
      err_count_q     <= '0;
    end else begin
      gen_state_q <= gen_state_d;
      chk_state_q <= chk_state_d;
      rd_vld_q    <= re;
      if (start) begin
        words_checked_q <= '0;
        err_count_q     <= '0;
      end else if (cmp_en) begin
        words_checked_q <= words_checked_q + 1'b1;
        if (mismatch) err_count_q <= sat_inc(err_count_q);
      end
    end
  end

  // Pattern and progress state; only meaningful while the owning FSM is running.
  always_ff @(posedge clk) begin
    if (start) begin
      gen_word_q  <= seed_eff;
      exp_word_q  <= seed_eff;
      written_q   <= '0;
      rd_issued_q <= '0;
      wc_q        <= word_count;
      sel_q       <= pattern_sel;
    end else begin
      if (we) begin
        gen_word_q <= pat_next(gen_word_q, sel_q);
        written_q  <= written_q + 1'b1;
      end
      if (re) rd_issued_q <= rd_issued_q + 1'b1;
      if (cmp_en) exp_word_q <= pat_next(exp_word_q, sel_q);
    end
  end

`ifdef DDR2_PATTERN_ERR_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (reset || start) begin
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_exp   <= '0;
      first_err_got   <= '0;
    end else if (cmp_en && mismatch && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_idx   <= words_checked_q;
      first_err_exp   <= exp_word_q;
      first_err_got   <= ob_dout;
    end
  end
`endif

  assign ib_we         = we;
  assign ib_din        = we ? gen_word_q : 32'h0;
  assign ob_re         = re;
  assign gen_done      = (gen_state_q == GEN_DONE);
  assign chk_done      = (chk_state_q == CHK_DONE);
  assign err_count     = err_count_q;
  assign words_checked = words_checked_q;

endmodule

// File: tb/tb_ddr2_pattern_gen_chk.sv
// Directed bench for ddr2_pattern_gen_chk with an ib->ob loopback FIFO model.
module tb_ddr2_pattern_gen_chk;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pattern_sel = 1'b0;
  logic [31:0] seed = 32'h0;
  logic [24:0] word_count = '0;
  logic        ib_we;
  logic [31:0] ib_din;
  logic [10:0] ib_count = '0;
  logic        ob_re;
  logic [31:0] ob_dout = 32'h0;
  logic        ob_empty;
  logic        gen_done;
  logic        chk_done;
  logic [31:0] err_count;
  logic [24:0] words_checked;
`ifdef DDR2_PATTERN_ERR_CAPTURE_EN
  logic        first_err_valid;
  logic [24:0] first_err_idx;
  logic [31:0] first_err_exp;
  logic [31:0] first_err_got;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:2047];
  int wp = 0, rp = 0, we_cnt = 0, re_cnt = 0;
  int corrupt_idx = -1;

  always #5 clk = ~clk;

  ddr2_pattern_gen_chk dut (
    .clk(clk), .reset(reset), .start(start), .pattern_sel(pattern_sel), .seed(seed),
    .word_count(word_count), .ib_we(ib_we), .ib_din(ib_din), .ib_count(ib_count),
    .ob_re(ob_re), .ob_dout(ob_dout), .ob_empty(ob_empty), .gen_done(gen_done),
    .chk_done(chk_done), .err_count(err_count), .words_checked(words_checked)
`ifdef DDR2_PATTERN_ERR_CAPTURE_EN
    , .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got)
`endif
  );

  // Loopback: every word written to ib_ appears in ob_, optionally with bit 0 flipped on one index.
  assign ob_empty = (wp == rp);
  always @(posedge clk) begin
    if (reset || start) begin
      wp <= 0; rp <= 0; we_cnt <= 0; re_cnt <= 0;
    end else begin
      if (ib_we) begin
        mem[wp[10:0]] <= ib_din ^ {31'd0, (we_cnt == corrupt_idx)};
        wp <= wp + 1;
        we_cnt <= we_cnt + 1;
      end
      if (ob_re) begin
        ob_dout <= mem[rp[10:0]];
        rp <= rp + 1;
        re_cnt <= re_cnt + 1;
      end
    end
  end

  task automatic pulse_start(input logic sel, input logic [31:0] sd, input logic [24:0] wc);
    @(negedge clk);
    pattern_sel = sel; seed = sd; word_count = wc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic wait_chk_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (chk_done === 1'b1) break;
      @(negedge clk); #1;
    end
    checks++;
    if (chk_done !== 1'b1) begin errors++; $display("FAIL chk_done_timeout got %b want 1", chk_done); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({ib_we, ob_re, gen_done, chk_done} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {ib_we, ob_re, gen_done, chk_done});
    end
    checks++;
    if (ib_din !== 32'h0 || err_count !== 32'h0 || words_checked !== 25'd0) begin
      errors++; $display("FAIL reset_data got din=%h err=%0d wc=%0d want 0", ib_din, err_count, words_checked);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_lfsr;
    logic [31:0] exp_w [8];
    exp_w = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001,
              32'hB02C0003, 32'hD8360002, 32'h6C1B0001, 32'hB62D8003};
    pulse_start(1'b0, 32'h1, 25'd8);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (ib_we !== 1'b1 || ib_din !== exp_w[i]) begin
        errors++; $display("FAIL lfsr_word%0d got we=%b din=%h want we=1 din=%h", i, ib_we, ib_din, exp_w[i]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (ib_we !== 1'b0 || gen_done !== 1'b1) begin
      errors++; $display("FAIL lfsr_gen_done got we=%b done=%b want we=0 done=1", ib_we, gen_done);
    end
    wait_chk_done(50);
    checks++;
    if (err_count !== 32'd0 || words_checked !== 25'd8) begin
      errors++; $display("FAIL lfsr_check got err=%0d words=%0d want 0/8", err_count, words_checked);
    end
  endtask

  task automatic test_loopback_index;
    pulse_start(1'b1, 32'h0, 25'd1000);
    wait_chk_done(3000);
    checks++;
    if (err_count !== 32'd0 || words_checked !== 25'd1000 || gen_done !== 1'b1) begin
      errors++; $display("FAIL idx_result got err=%0d words=%0d gdone=%b want 0/1000/1", err_count, words_checked, gen_done);
    end
    checks++;
    if (re_cnt != 1000 || we_cnt != 1000) begin
      errors++; $display("FAIL idx_strobes got re=%0d we=%0d want 1000/1000", re_cnt, we_cnt);
    end
  endtask

  task automatic test_corrupt;
    corrupt_idx = 17;
    pulse_start(1'b1, 32'h0, 25'd40);
    wait_chk_done(200);
    checks++;
    if (err_count !== 32'd1 || words_checked !== 25'd40) begin
      errors++; $display("FAIL corrupt_count got err=%0d words=%0d want 1/40", err_count, words_checked);
    end
`ifdef DDR2_PATTERN_ERR_CAPTURE_EN
    checks++;
    if (first_err_valid !== 1'b1 || first_err_idx !== 25'd17 || first_err_exp !== 32'd17 || first_err_got !== 32'd16) begin
      errors++; $display("FAIL corrupt_capture got v=%b idx=%0d exp=%h got=%h want 1/17/11/10",
                         first_err_valid, first_err_idx, first_err_exp, first_err_got);
    end
`endif
    corrupt_idx = -1;
  endtask

  task automatic test_stall;
    pulse_start(1'b1, 32'h0, 25'd20);
    repeat (5) @(negedge clk);
    ib_count = 11'd1022;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (ib_we !== 1'b0) begin errors++; $display("FAIL stall_we%0d got %b want 0", i, ib_we); end
    end
    @(negedge clk);
    ib_count = 11'd1021;
    #1;
    checks++;
    if (ib_we !== 1'b1 || ib_din !== 32'd5) begin
      errors++; $display("FAIL stall_resume got we=%b din=%h want we=1 din=5", ib_we, ib_din);
    end
    @(negedge clk); ib_count = '0;
    wait_chk_done(200);
    checks++;
    if (err_count !== 32'd0 || words_checked !== 25'd20) begin
      errors++; $display("FAIL stall_result got err=%0d words=%0d want 0/20", err_count, words_checked);
    end
  endtask

  task automatic test_restart;
    pulse_start(1'b1, 32'h0, 25'd100);
    for (int i = 0; i < 500; i++) begin
      if (words_checked >= 25'd50) break;
      @(negedge clk); #1;
    end
    checks++;
    if (words_checked !== 25'd50) begin errors++; $display("FAIL restart_mid got %0d want 50", words_checked); end
    pulse_start(1'b1, 32'h0, 25'd100);
    checks++;
    if (words_checked !== 25'd0 || err_count !== 32'd0 || ib_we !== 1'b1 || ib_din !== 32'd0) begin
      errors++; $display("FAIL restart_clear got words=%0d err=%0d we=%b din=%h want 0/0/1/0",
                         words_checked, err_count, ib_we, ib_din);
    end
    wait_chk_done(500);
    checks++;
    if (words_checked !== 25'd100 || err_count !== 32'd0 || re_cnt != 100) begin
      errors++; $display("FAIL restart_result got words=%0d err=%0d re=%0d want 100/0/100", words_checked, err_count, re_cnt);
    end
  endtask

  task automatic test_zero;
    pulse_start(1'b0, 32'h0, 25'd0);
    checks++;
    if ({gen_done, chk_done, ib_we, ob_re} !== 4'b1100) begin
      errors++; $display("FAIL zero_done got %b want 1100", {gen_done, chk_done, ib_we, ob_re});
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (we_cnt != 0 || re_cnt != 0 || gen_done !== 1'b1) begin
      errors++; $display("FAIL zero_strobes got we=%0d re=%0d gdone=%b want 0/0/1", we_cnt, re_cnt, gen_done);
    end
    pulse_start(1'b0, 32'h0, 25'd3);
    checks++;
    if (ib_we !== 1'b1 || ib_din !== 32'h1) begin
      errors++; $display("FAIL zero_seed got we=%b din=%h want 1/00000001", ib_we, ib_din);
    end
    @(negedge clk); #1;
    checks++;
    if (ib_din !== 32'h80200003) begin errors++; $display("FAIL zero_seed_next got %h want 80200003", ib_din); end
    wait_chk_done(50);
  endtask

  task automatic test_reset_mid;
    pulse_start(1'b1, 32'h0, 25'd100);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({ib_we, ob_re, gen_done, chk_done} !== 4'b0 || ib_din !== 32'h0 || err_count !== 32'h0 || words_checked !== 25'd0) begin
      errors++; $display("FAIL reset_mid got ctrl=%b din=%h err=%0d words=%0d want 0",
                         {ib_we, ob_re, gen_done, chk_done}, ib_din, err_count, words_checked);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (we_cnt != 0 || re_cnt != 0) begin
      errors++; $display("FAIL reset_mid_strobes got we=%0d re=%0d want 0/0", we_cnt, re_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lfsr();
    test_loopback_index();
    test_corrupt();
    test_stall();
    test_restart();
    test_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
